mutex_grant_sync4: RTL and testbench
====================================

Name: mutex_grant_sync4

Overview:
- Clocked handshake stage directly downstream of the 4-way mutex arbiter tree, which is built from cross-coupled 2-input mutex cells.
- Registers client requests onto the mutex request lines and synchronizes the asynchronous mutex grants into the CLK domain.
- Filters grants until they are stable, then runs a per-channel 4-phase req/gnt handshake with clients.
- Enforces a hold timeout, and flags any grant that violates mutual exclusion.

Parameters:
- SYNC_STAGES, 2: flops in each grant synchronizer; legal range 2..4.
- SETTLE, 2: consecutive high synced samples required before a grant is accepted; legal range 1..7.
- MAX_HOLD, 16: maximum GNT cycles per channel. 0 disables the timeout. 8-bit counter, so MAX_HOLD ≤ 255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset; deassertion is synchronous to CLK upstream.
- REQ  in  4  client requests, synchronous to CLK, level-sensitive, one bit per channel.
- MX_REQ  out  4  registered request lines to the mutex tree inputs.
- MX_GNT  in  4  asynchronous grant lines from the mutex tree outputs.
- GNT  out  4  registered client grants; at most one bit high.
- TIMEOUT  out  4  one-cycle pulse per channel on forced release.
- ERR  out  1  sticky mutual-exclusion violation flag.

Behaviour:
- Reset (RST_N low, asynchronous):
  - MX_REQ, GNT, TIMEOUT = 0 and ERR = 0.
  - All synchronizer flops, settle counters and hold counters = 0.
  - All channel FSMs = IDLE.
- Synchronizer: each MX_GNT bit passes through SYNC_STAGES flops to give sg[i]; no other logic touches the raw MX_GNT.
- Per-channel FSM states: IDLE, ARB, GRANTED, REL, WAITLOW.
- IDLE:
  - REQ[i]=1 → ARB.
  - MX_REQ[i] goes high on the same edge; latency from REQ to MX_REQ is 1 cycle.
- ARB:
  - Settle counter increments while sg[i]=1 and clears to 0 when sg[i]=0.
  - Counter reaching SETTLE → GRANTED, with GNT[i] high on that edge.
  - Minimum latency from an MX_GNT rising edge to GNT is SYNC_STAGES+SETTLE cycles.
  - REQ[i]=0 while in ARB → REL, MX_REQ[i] low next edge; the mutex may already have granted.
- GRANTED:
  - GNT[i]=1 and the hold counter increments each cycle.
  - REQ[i]=0 → REL; GNT[i] and MX_REQ[i] low on that edge.
  - Hold count reaching MAX_HOLD with REQ[i] still 1 (MAX_HOLD≠0) → WAITLOW. GNT[i] and MX_REQ[i] go low, and TIMEOUT[i] pulses for exactly 1 cycle.
- WAITLOW: stay until REQ[i]=0, then → REL. Keeping REQ high never re-arbitrates.
- REL:
  - MX_REQ[i]=0 and GNT[i]=0.
  - Stay until sg[i]=0 for one sample, then → IDLE.
  - REQ[i] re-asserted during REL is ignored until IDLE is reached; it is then accepted on the next edge.
- Counters clear on every entry to ARB and to GRANTED.
- ERR is set (sticky, cleared only by reset) when either of these holds:
  - more than one sg bit is high in the same cycle;
  - sg[i]=1 for 2+ consecutive cycles while channel i is in IDLE.
- ERR does not alter FSM behaviour. GNT stays one-hot-or-zero by construction, because GRANTED is only entered on a settled sg[i].
- Simultaneous requests: all requesting channels raise MX_REQ together, and the mutex tree picks the winner. Losers stay in ARB until the winner releases and the tree re-grants.
- Glitch handling: a grant pulse shorter than SETTLE synced cycles is never forwarded.
- Reset mid-operation: all outputs drop immediately (asynchronously) and no TIMEOUT pulse is emitted.

Test Plan:
- Single request: REQ=0001 at cycle 0; model tree returns MX_GNT[0] at cycle 2. Expect MX_REQ=0001 at cycle 1 and GNT=0001 at cycle 2+2+2=6. Drop REQ at cycle 10 → GNT=0 and MX_REQ=0 at cycle 11; IDLE after sg[0] falls.
- Contention: REQ=1111 at once; model grants channel 2 first. Expect GNT=0100 only. After REQ[2] drops, the next grant (channel 0) appears and GNT is never multi-hot. ERR stays 0.
- Timeout: MAX_HOLD=16, REQ[1] held high. Expect GNT[1] high for exactly 16 cycles, then a TIMEOUT[1] 1-cycle pulse. No new grant until REQ[1] is low and sg[1] is low.
- Glitch: 1-cycle MX_GNT[3] pulse with REQ[3]=1 and SETTLE=2. Expect GNT[3] to stay 0 and the FSM to remain in ARB.
- Violation: force MX_GNT=0011 for 3 cycles. Expect ERR=1 within SYNC_STAGES+1 cycles, still 1 after MX_GNT clears, and 0 only after RST_N pulse.
- Reset mid-grant: RST_N low during GRANTED. Expect GNT, MX_REQ, TIMEOUT and ERR all 0 asynchronously, and all FSMs in IDLE on release.

Source files
------------

// File: rtl/mutex_grant_sync4.sv
// Clocked handshake stage behind a 4-way mutex arbiter tree: synchronizes and settles
// the asynchronous grants, then runs a per-channel 4-phase req/gnt handshake with clients.
module mutex_grant_sync4 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  output logic [3:0] mx_req_o,
  input  logic [3:0] mx_gnt_i,
  output logic [3:0] gnt_o,
  output logic [3:0] timeout_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_GRANTED = 3'd2,
    ST_REL     = 3'd3,
    ST_WAITLOW = 3'd4
  } state_e;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [8:0] HOLD_L   = 9'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 32'd0);

  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [3:0]             sg_s;
  logic [3:0]             idle_now_s;
  state_e                 state_q  [4];
  state_e                 state_d  [4];
  logic [2:0]             settle_q [4];
  logic [2:0]             settle_d [4];
  logic [7:0]             hold_q   [4];
  logic [7:0]             hold_d   [4];
  logic [3:0]             idle_hi_q, idle_hi_d;
  logic [3:0]             mx_req_q, mx_req_d;
  logic [3:0]             gnt_q, gnt_d;
  logic [3:0]             timeout_q, timeout_d;
  logic                   err_q, err_d;

  // Raw mutex grants are only ever observed through these synchronizer chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) sync_q[i] <= {SYNC_STAGES{1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], mx_gnt_i[i]};
    end
  end

  // Per-channel handshake FSMs, counters and the mutual-exclusion monitor
  always_comb begin
    sg_s       = 4'd0;
    idle_now_s = 4'd0;
    idle_hi_d  = 4'd0;
    mx_req_d   = 4'd0;
    gnt_d      = 4'd0;
    timeout_d  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sg_s[i]       = sync_q[i][SYNC_STAGES-1];
      state_d[i]    = state_q[i];
      settle_d[i]   = settle_q[i];
      hold_d[i]     = hold_q[i];
      idle_now_s[i] = (state_q[i] == ST_IDLE);
      idle_hi_d[i]  = idle_now_s[i] & sg_s[i];
      case (state_q[i])
        ST_IDLE: begin
          if (req_i[i]) begin
            state_d[i]  = ST_ARB;
            settle_d[i] = 3'd0;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_ARB: begin
          if (!req_i[i]) begin
            state_d[i] = ST_REL;
          end else if (sg_s[i]) begin
            if (({1'b0, settle_q[i]} + 4'd1) == SETTLE_L) begin
              state_d[i] = ST_GRANTED;
              hold_d[i]  = 8'd0;
            end else begin
              settle_d[i] = settle_q[i] + 3'd1;
            end
          end else begin
            settle_d[i] = 3'd0;
          end
        end
        ST_GRANTED: begin
          if (!req_i[i]) begin
            state_d[i] = ST_REL;
          end else if (HOLD_EN && (({1'b0, hold_q[i]} + 9'd1) == HOLD_L)) begin
            state_d[i]   = ST_WAITLOW;
            timeout_d[i] = 1'b1;
          end else if (hold_q[i] != 8'hFF) begin
            hold_d[i] = hold_q[i] + 8'd1;
          end else begin
            hold_d[i] = hold_q[i];
          end
        end
        ST_WAITLOW: begin
          if (!req_i[i]) state_d[i] = ST_REL;
          else           state_d[i] = ST_WAITLOW;
        end
        ST_REL: begin
          // Wait for the tree to actually drop its grant before re-arming
          if (!sg_s[i]) state_d[i] = ST_IDLE;
          else          state_d[i] = ST_REL;
        end
        default: state_d[i] = ST_IDLE;
      endcase
      mx_req_d[i] = (state_d[i] == ST_ARB) || (state_d[i] == ST_GRANTED);
      gnt_d[i]    = (state_d[i] == ST_GRANTED);
    end
    err_d = err_q | multi_hot(sg_s) | (|(idle_hi_q & sg_s & idle_now_s));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= ST_IDLE;
        settle_q[i] <= 3'd0;
        hold_q[i]   <= 8'd0;
      end
      idle_hi_q <= 4'd0;
      mx_req_q  <= 4'd0;
      gnt_q     <= 4'd0;
      timeout_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= state_d[i];
        settle_q[i] <= settle_d[i];
        hold_q[i]   <= hold_d[i];
      end
      idle_hi_q <= idle_hi_d;
      mx_req_q  <= mx_req_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign mx_req_o  = mx_req_q;
  assign gnt_o     = gnt_q;
  assign timeout_o = timeout_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mutex_grant_sync4.sv
// Directed bench for mutex_grant_sync4: a small mutex-tree stand-in drives MX_GNT, and an
// event-time model of the handshake rules is compared against the DUT on every cycle.
module tb_mutex_grant_sync4;
  localparam int SYNC     = 2;
  localparam int SETTLE   = 2;
  localparam int MAX_HOLD = 16;

  logic       clk, rst_n;
  logic [3:0] req, mx_req, mx_gnt, gnt, timeout;
  logic       err;
  int         checks = 0;
  int         failures = 0;
  logic       tree_auto;
  logic [3:0] dir_gnt;

  mutex_grant_sync4 #(.SYNC_STAGES(SYNC), .SETTLE(SETTLE), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .mx_req_o(mx_req), .mx_gnt_i(mx_gnt),
    .gnt_o(gnt), .timeout_o(timeout), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mutex tree stand-in: reacts one cycle late to MX_REQ, fixed preference order 2,0,1,3
  int         holder;
  logic [3:0] mreq_prev;
  int         pref [4] = '{2, 0, 1, 3};
  initial begin
    holder = -1;
    mreq_prev = 4'b0000;
    mx_gnt = 4'b0000;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        holder = -1;
        mreq_prev = 4'b0000;
      end else begin
        if (holder >= 0) begin
          if (!mreq_prev[holder]) holder = -1;
        end else begin
          for (int p = 0; p < 4; p++)
            if (holder < 0 && mreq_prev[pref[p]]) holder = pref[p];
        end
        mreq_prev = mx_req;
      end
      mx_gnt = tree_auto ? ((holder >= 0) ? (4'b0001 << holder) : 4'b0000) : dir_gnt;
    end
  end

  // Behavioural model in event-time form
  typedef enum int {P_FREE, P_WAIT, P_OWN, P_LOCK, P_DRAIN} phase_t;
  phase_t     ph [4];
  int         hi_from [4];
  int         own_from [4];
  logic [7:0] hist [4];
  logic [3:0] idle_hi;
  int         ncyc;
  logic [3:0] m_req, m_gnt, m_to;
  logic       m_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ph[i] = P_FREE;
      hi_from[i] = 0;
      own_from[i] = 0;
      hist[i] = 8'd0;
    end
    idle_hi = 4'b0000;
    ncyc = 0;
    m_req = 4'b0000;
    m_gnt = 4'b0000;
    m_to = 4'b0000;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] sgv;
    int nhi;
    ncyc++;
    nhi = 0;
    for (int i = 0; i < 4; i++) begin
      sgv[i] = hist[i][SYNC-1];
      if (sgv[i]) nhi++;
    end
    if (nhi > 1) m_err = 1'b1;
    m_to = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (ph[i] == P_FREE && sgv[i] && idle_hi[i]) m_err = 1'b1;
      idle_hi[i] = (ph[i] == P_FREE) && sgv[i];
      case (ph[i])
        P_FREE:  if (req[i]) begin ph[i] = P_WAIT; hi_from[i] = ncyc + 1; end
        P_WAIT: begin
          if (!req[i]) ph[i] = P_DRAIN;
          else if (!sgv[i]) hi_from[i] = ncyc + 1;
          else if (ncyc - hi_from[i] + 1 >= SETTLE) begin ph[i] = P_OWN; own_from[i] = ncyc; end
        end
        P_OWN: begin
          if (!req[i]) ph[i] = P_DRAIN;
          else if (MAX_HOLD != 0 && ncyc - own_from[i] >= MAX_HOLD) begin
            ph[i] = P_LOCK;
            m_to[i] = 1'b1;
          end
        end
        P_LOCK:  if (!req[i]) ph[i] = P_DRAIN;
        P_DRAIN: if (!sgv[i]) ph[i] = P_FREE;
        default: ph[i] = P_FREE;
      endcase
      m_req[i] = (ph[i] == P_WAIT) || (ph[i] == P_OWN);
      m_gnt[i] = (ph[i] == P_OWN);
      hist[i] = {hist[i][6:0], mx_gnt[i]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check4("gnt", gnt, m_gnt);
      check4("mx_req", mx_req, m_req);
      check4("timeout", timeout, m_to);
      check4("err", {3'b000, err}, {3'b000, m_err});
      check4("gnt_onehot", {3'b000, (gnt & (gnt - 4'd1)) != 4'd0}, 4'b0000);
    end
  end

  int gcnt, tcnt;

  initial begin
    rst_n = 1'b0; req = 4'b0000; dir_gnt = 4'b0000; tree_auto = 1'b1;
    step(); step();
    check4("rst_gnt", gnt, 4'b0000);
    check4("rst_mx_req", mx_req, 4'b0000);
    check4("rst_err", {3'b000, err}, 4'b0000);
    rst_n = 1'b1;
    step(); step(); step();

    // Single request, drop, re-request during REL
    req = 4'b0001;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1)  check4("t1_mx_req_c1", mx_req, 4'b0001);
      if (k == 5)  check4("t1_gnt_c5", gnt, 4'b0000);
      if (k == 6)  begin check4("t1_gnt_c6", gnt, 4'b0001); check4("model_gnt_c6", m_gnt, 4'b0001); end
      if (k == 10) req = 4'b0000;
      if (k == 11) begin check4("t1_gnt_c11", gnt, 4'b0000); check4("t1_mx_req_c11", mx_req, 4'b0000); end
      if (k == 12) req = 4'b0001;
      if (k == 15) check4("t1_rel_ignores_req", mx_req, 4'b0000);
      if (k == 16) check4("t1_rearm_c16", mx_req, 4'b0001);
      if (k == 20) check4("t1_regnt_c20", gnt, 4'b0000);
      if (k == 21) check4("t1_regnt_c21", gnt, 4'b0001);
      if (k == 22) req = 4'b0000;
    end

    // Contention: tree picks channel 2, then channel 0
    req = 4'b1111;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 5)  check4("t2_gnt_c5", gnt, 4'b0000);
      if (k == 6)  begin check4("t2_gnt_c6", gnt, 4'b0100); check4("model_gnt_t2", m_gnt, 4'b0100); end
      if (k == 10) req = 4'b1011;
      if (k == 11) check4("t2_gnt_c11", gnt, 4'b0000);
      if (k == 16) check4("t2_gnt_c16", gnt, 4'b0000);
      if (k == 17) check4("t2_gnt_c17", gnt, 4'b0001);
      if (k == 20) req = 4'b0000;
      if (k == 25) check4("t2_err", {3'b000, err}, 4'b0000);
    end

    // Hold timeout on channel 1
    gcnt = 0; tcnt = 0;
    req = 4'b0010;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (gnt[1]) gcnt++;
      if (timeout[1]) tcnt++;
      if (k == 21) check4("t3_gnt_c21", gnt, 4'b0010);
      if (k == 22) begin check4("t3_gnt_c22", gnt, 4'b0000); check4("t3_to_c22", timeout, 4'b0010); end
      if (k == 23) check4("t3_to_c23", timeout, 4'b0000);
      if (k == 40) begin check4("t3_no_rearb", mx_req, 4'b0000); req = 4'b0000; end
    end
    checkn("t3_hold_cycles", gcnt, 16);
    checkn("t3_timeout_pulses", tcnt, 1);

    // Glitch on channel 3, then a real grant
    tree_auto = 1'b0;
    req = 4'b1000;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (k == 3)  dir_gnt = 4'b1000;
      if (k == 4)  dir_gnt = 4'b0000;
      if (k == 11) begin check4("t4_glitch_gnt", gnt, 4'b0000); check4("t4_still_arb", mx_req, 4'b1000); end
      if (k == 12) dir_gnt = 4'b1000;
      if (k == 15) check4("t4_gnt_c15", gnt, 4'b0000);
      if (k == 16) check4("t4_gnt_c16", gnt, 4'b1000);
      if (k == 17) req = 4'b0000;
      if (k == 19) dir_gnt = 4'b0000;
    end

    // Mutual-exclusion violation, sticky until reset
    dir_gnt = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 2)  check4("t5_err_c2", {3'b000, err}, 4'b0000);
      if (k == 3)  begin check4("t5_err_c3", {3'b000, err}, 4'b0001); dir_gnt = 4'b0000; end
      if (k == 10) check4("t5_err_sticky", {3'b000, err}, 4'b0001);
    end
    #2 rst_n = 1'b0;
    #1 check4("t5_err_rst", {3'b000, err}, 4'b0000);
    step();
    rst_n = 1'b1;
    step();

    // Reset in the middle of a grant
    tree_auto = 1'b1;
    req = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 6) check4("t6_gnt_c6", gnt, 4'b0001);
    end
    #2 rst_n = 1'b0;
    #1;
    check4("t6_gnt_async", gnt, 4'b0000);
    check4("t6_mx_req_async", mx_req, 4'b0000);
    check4("t6_timeout_async", timeout, 4'b0000);
    check4("t6_err_async", {3'b000, err}, 4'b0000);
    req = 4'b0000;
    step(); step();
    rst_n = 1'b1;
    step();
    check4("t6_idle_mx_req", mx_req, 4'b0000);
    req = 4'b0001;
    step();
    check4("t6_idle_accept", mx_req, 4'b0001);
    for (int k = 1; k <= 8; k++) step();
    req = 4'b0000;
    for (int k = 1; k <= 8; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
